// File: rtl/prog_memory_loader.sv
// Program memory loader: streams instruction words into memory in LOAD, serves fetches in RUN.
// Fetch latency 1 cycle; load_ready drops when memory is full, and fetches issued during LOAD are dropped.
module prog_memory_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 17,
    parameter int DEPTH   = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_end,
    output logic               load_ready,
    output logic [ADDR_W:0]    load_count,
    output logic               load_ovf,
    output logic               busy,
    input  logic               fetch_req,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic [INSTR_W-1:0] fetch_data,
    output logic               fetch_valid
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    logic [1:0]         state_q, state_d;
    logic [ADDR_W:0]    load_count_q, load_count_d;
    logic               load_ovf_q, load_ovf_d;
    logic               fetch_valid_q, fetch_valid_d;
    logic [INSTR_W-1:0] fetch_data_q, fetch_data_d;
    logic               mem_we;
    logic               full;

    logic [INSTR_W-1:0] mem [0:DEPTH-1];

    // load_count doubles as the write pointer; it never wraps.
    assign full       = (load_count_q >= DEPTH_C);
    assign load_ready = (state_q == S_LOAD) && !full;
    assign busy       = (state_q == S_LOAD);
    assign load_count = load_count_q;
    assign load_ovf   = load_ovf_q;
    assign fetch_data  = fetch_data_q;
    assign fetch_valid = fetch_valid_q;

    always_comb begin
        state_d      = state_q;
        load_count_d = load_count_q;
        load_ovf_d   = load_ovf_q;
        mem_we       = 1'b0;

        if (load_start) begin
            state_d      = S_LOAD;
            load_count_d = '0;
            load_ovf_d   = 1'b0;
        end else if (state_q == S_LOAD) begin
            if (load_valid) begin
                if (!full) begin
                    mem_we       = 1'b1;
                    load_count_d = load_count_q + ONE_C;
                end else begin
                    load_ovf_d = 1'b1;
                end
            end
            if (load_end) begin
                state_d = S_RUN;
            end
        end
    end

    // Fetch response is decided by the state at the request cycle; LOAD stalls the core.
    always_comb begin
        fetch_valid_d = 1'b0;
        fetch_data_d  = fetch_data_q;
        if (fetch_req) begin
            if (state_q == S_RUN) begin
                fetch_valid_d = 1'b1;
                if ({1'b0, fetch_addr} < DEPTH_C) begin
                    fetch_data_d = mem[fetch_addr];
                end else begin
                    fetch_data_d = '0;
                end
            end else if (state_q == S_IDLE) begin
                fetch_valid_d = 1'b1;
                fetch_data_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            load_count_q  <= '0;
            load_ovf_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            load_count_q  <= load_count_d;
            load_ovf_q    <= load_ovf_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
        end
    end

    // Memory contents survive reset; only the write is suppressed while reset is low.
    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            mem[load_count_q[ADDR_W-1:0]] <= load_data;
        end
    end

endmodule

// File: tb/tb_prog_memory_loader.sv
// Directed bench for prog_memory_loader with a 4-word memory; expected values are hand-computed constants.
module tb_prog_memory_loader;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 17;
    localparam int DEPTH   = 4;

    logic               clk;
    logic               reset;
    logic               load_start;
    logic               load_valid;
    logic [INSTR_W-1:0] load_data;
    logic               load_end;
    logic               load_ready;
    logic [ADDR_W:0]    load_count;
    logic               load_ovf;
    logic               busy;
    logic               fetch_req;
    logic [ADDR_W-1:0]  fetch_addr;
    logic [INSTR_W-1:0] fetch_data;
    logic               fetch_valid;

    int n_tests;
    int n_fail;

    prog_memory_loader #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_end   (load_end),
        .load_ready (load_ready),
        .load_count (load_count),
        .load_ovf   (load_ovf),
        .busy       (busy),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .fetch_valid(fetch_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so registered outputs can be sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [INSTR_W-1:0] w);
        load_valid = 1'b1;
        load_data  = w;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a, input string tag, input logic [INSTR_W-1:0] exp);
        fetch_req  = 1'b1;
        fetch_addr = a;
        tick();
        fetch_req  = 1'b0;
        chk({tag, "_vld"}, 32'(fetch_valid), 32'd1);
        chk({tag, "_dat"}, 32'(fetch_data), 32'(exp));
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_end   = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;

        // Reset state
        tick();
        tick();
        reset = 1'b1;
        chk("rst_count", 32'(load_count), 32'd0);
        chk("rst_ovf",   32'(load_ovf),   32'd0);
        chk("rst_ready", 32'(load_ready), 32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_fvld",  32'(fetch_valid), 32'd0);
        chk("rst_fdat",  32'(fetch_data), 32'd0);

        // IDLE fetch returns NOP
        fetch(8'd5, "idle_fetch", 17'h0);
        chk("idle_busy", 32'(busy), 32'd0);
        tick();
        chk("no_req_vld", 32'(fetch_valid), 32'd0);

        // Load three words and run
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("load_busy",  32'(busy),       32'd1);
        chk("load_ready", 32'(load_ready), 32'd1);
        load_word(17'h12400);
        load_word(17'h08A04);
        load_word(17'h0AA04);
        chk("load3_count", 32'(load_count), 32'd3);
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        chk("run_busy",  32'(busy),       32'd0);
        chk("run_ready", 32'(load_ready), 32'd0);
        fetch(8'd0, "run_f0", 17'h12400);
        fetch(8'd1, "run_f1", 17'h08A04);
        fetch(8'd2, "run_f2", 17'h0AA04);
        tick();
        chk("hold_vld", 32'(fetch_valid), 32'd0);
        chk("hold_dat", 32'(fetch_data),  32'h0AA04);
        load_word(17'h1FFFF);
        chk("run_ignore_valid", 32'(load_count), 32'd3);

        // Overflow at DEPTH=4
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_word(17'h00001);
        load_word(17'h00002);
        load_word(17'h00003);
        load_word(17'h00004);
        chk("full_ready", 32'(load_ready), 32'd0);
        chk("full_count", 32'(load_count), 32'd4);
        chk("full_ovf0",  32'(load_ovf),   32'd0);
        load_word(17'h1ABCD);
        chk("ovf_set",   32'(load_ovf),   32'd1);
        chk("ovf_count", 32'(load_count), 32'd4);
        tick();
        chk("ovf_sticky", 32'(load_ovf), 32'd1);
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        fetch(8'd0, "ovf_mem0", 17'h00001);
        fetch(8'd3, "ovf_mem3", 17'h00004);
        fetch(8'd4, "oor_depth", 17'h0);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 17'h1FFFF;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        chk("restart_ovf",   32'(load_ovf),   32'd0);
        chk("restart_count", 32'(load_count), 32'd0);
        chk("restart_busy",  32'(busy),       32'd1);

        // Simultaneous load_valid + load_end
        load_word(17'h00100);
        load_word(17'h00200);
        load_valid = 1'b1;
        load_end   = 1'b1;
        load_data  = 17'h0E000;
        tick();
        load_valid = 1'b0;
        load_end   = 1'b0;
        chk("vend_busy",  32'(busy),       32'd0);
        chk("vend_count", 32'(load_count), 32'd3);
        fetch(8'd2, "vend_f2", 17'h0E000);
        fetch(8'd0, "restart_f0", 17'h00100);

        // load_start + load_end in RUN with fetch_req held
        load_start = 1'b1;
        load_end   = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 8'd2;
        tick();
        load_start = 1'b0;
        load_end   = 1'b0;
        chk("se_busy",  32'(busy),        32'd1);
        chk("se_vld_run_req", 32'(fetch_valid), 32'd1);
        tick();
        chk("se_vld_load", 32'(fetch_valid), 32'd0);
        tick();
        chk("se_vld_load2", 32'(fetch_valid), 32'd0);
        chk("se_dat_hold",  32'(fetch_data),  32'h0E000);
        fetch_req = 1'b0;

        // Reset mid-load, reset wins over load_start
        load_word(17'h01111);
        load_word(17'h02222);
        chk("mid_count", 32'(load_count), 32'd2);
        reset      = 1'b0;
        load_start = 1'b1;
        tick();
        reset      = 1'b1;
        load_start = 1'b0;
        chk("mrst_busy",  32'(busy),       32'd0);
        chk("mrst_count", 32'(load_count), 32'd0);
        chk("mrst_ready", 32'(load_ready), 32'd0);
        fetch(8'd0, "mrst_idle_f0", 17'h0);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_word(17'h03333);
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        fetch(8'd0, "reload_f0", 17'h03333);
        fetch(8'd1, "reload_f1", 17'h02222);

        // Out-of-range fetch
        fetch(8'd200, "oor_200", 17'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
